// File: rtl/logic_arb_pkg.sv
// -----------------------------------------------------------------------------
// logic_arb_pkg
// Shared definitions for the logic-unit arbiter slice:
//   - opcode width and opcode encodings of the bitwise gate set
//   - widths of the optional statistics counters (LOGIC_ARB_STATS_EN)
//   - result-slot state type
// No ports (package).
// -----------------------------------------------------------------------------
package logic_arb_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd2;  // NOT A, operand B ignored
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
   localparam logic [OP_W-1:0] OP_RSVD = 3'd7;  // yields 0 and raises err

   localparam int GRANT_CNT_W = 16;
   localparam int ERR_CNT_W   = 8;

   // Single-entry output register occupancy.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter_if
// Request/response bundle between NREQ command sources and the arbiter.
//   req_valid [NREQ]        per-requester request valid
//   req_op    [3*NREQ]      opcode of requester i at [3i+2:3i]
//   req_a/b   [WIDTH*NREQ]  operands of requester i at [WIDTH*i +: WIDTH]
//   req_ready [NREQ]        one-hot accept from the arbiter
//   rsp_valid/rsp_ready     result handshake
//   rsp_data  [WIDTH]       result
//   rsp_id    [IDW]         requester that produced the result
//   rsp_err                 opcode was reserved
// Modports: master = requesters/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface logic_unit_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
);

   logic [NREQ-1:0]       req_valid;
   logic [3*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_a;
   logic [WIDTH*NREQ-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
   );

endinterface

// File: rtl/logic_op_unit.sv
// -----------------------------------------------------------------------------
// logic_op_unit
// Purely combinational WIDTH-wide bitwise gate unit. Every gate type is
// instantiated per bit as a gate cell; the opcode selects which bank drives
// the result.
//   op_i     [3]      opcode (see logic_arb_pkg)
//   a_i      [WIDTH]  operand A
//   b_i      [WIDTH]  operand B (ignored by NOT)
//   result_o [WIDTH]  selected gate output, 0 for the reserved opcode
//   err_o             high for the reserved opcode
// -----------------------------------------------------------------------------
module logic_op_unit
   import logic_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             err_o
);

   wire [WIDTH-1:0] and_w;
   wire [WIDTH-1:0] or_w;
   wire [WIDTH-1:0] not_w;
   wire [WIDTH-1:0] nand_w;
   wire [WIDTH-1:0] nor_w;
   wire [WIDTH-1:0] xor_w;
   wire [WIDTH-1:0] xnor_w;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         and  u_and  (and_w[gi],  a_i[gi], b_i[gi]);
         or   u_or   (or_w[gi],   a_i[gi], b_i[gi]);
         not  u_not  (not_w[gi],  a_i[gi]);
         nand u_nand (nand_w[gi], a_i[gi], b_i[gi]);
         nor  u_nor  (nor_w[gi],  a_i[gi], b_i[gi]);
         xor  u_xor  (xor_w[gi],  a_i[gi], b_i[gi]);
         xnor u_xnor (xnor_w[gi], a_i[gi], b_i[gi]);
      end
   endgenerate

   always_comb begin
      result_o = '0;
      err_o    = 1'b0;
      case (op_i)
         OP_AND:  result_o = and_w;
         OP_OR:   result_o = or_w;
         OP_NOT:  result_o = not_w;
         OP_NAND: result_o = nand_w;
         OP_NOR:  result_o = nor_w;
         OP_XOR:  result_o = xor_w;
         OP_XNOR: result_o = xnor_w;
         default: begin
            result_o = '0;
            err_o    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters.
// The winner's operands are muxed into a single logic_op_unit and its result
// is captured in a single-entry output register together with the winner ID.
// Drain and refill of the output register may happen in the same cycle.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        logic_unit_arbiter_if.slave (request / response handshake)
// Optional (macro LOGIC_ARB_STATS_EN):
//   grant_cnt  [16] accepted requests since reset, saturating
//   err_cnt    [8]  accepted reserved-opcode requests, saturating
// -----------------------------------------------------------------------------
module logic_unit_arbiter
   import logic_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   logic_unit_arbiter_if.slave    bus
`ifdef LOGIC_ARB_STATS_EN
   ,
   output logic [GRANT_CNT_W-1:0] grant_cnt,
   output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

   // Unpacked per-requester views of the packed request buses.
   logic [OP_W-1:0]  op_arr [NREQ];
   logic [WIDTH-1:0] a_arr  [NREQ];
   logic [WIDTH-1:0] b_arr  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign op_arr[gi] = bus.req_op[OP_W*gi +: OP_W];
         assign a_arr[gi]  = bus.req_a[WIDTH*gi +: WIDTH];
         assign b_arr[gi]  = bus.req_b[WIDTH*gi +: WIDTH];
      end
   endgenerate

   slot_state_e      state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] data_q;
   logic [IDW-1:0]   id_q;
   logic             err_q;

   logic [IDW-1:0]   winner;
   logic             grant_any;
   logic             slot_free;
   logic             grant;
   logic [NREQ-1:0]  req_ready_d;
   logic [WIDTH-1:0] alu_result;
   logic             alu_err;

   // First valid requester at or after ptr, wrapping at NREQ-1.
   always_comb begin
      int idx;
      idx       = 0;
      winner    = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_any && bus.req_valid[idx]) begin
            grant_any = 1'b1;
            winner    = IDW'(idx);
         end
      end
   end

   // The slot can accept a new result if empty or being drained this cycle.
   assign slot_free = (state_q == SLOT_EMPTY) || bus.rsp_ready;
   assign grant     = !rst && slot_free && grant_any;

   always_comb begin
      req_ready_d = '0;
      if (grant) req_ready_d[winner] = 1'b1;
   end

   assign bus.req_ready = req_ready_d;

   logic_op_unit #(
      .WIDTH (WIDTH)
   ) u_op (
      .op_i     (op_arr[winner]),
      .a_i      (a_arr[winner]),
      .b_i      (b_arr[winner]),
      .result_o (alu_result),
      .err_o    (alu_err)
   );

   always_comb begin
      ptr_d = ptr_q;
      if (grant) begin
         ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      end
   end

   // Slot occupancy: a grant always leaves it FULL; a drain without a grant
   // empties it; otherwise it holds.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SLOT_EMPTY: if (grant) state_d = SLOT_FULL;
         SLOT_FULL: begin
            if (grant)              state_d = SLOT_FULL;
            else if (bus.rsp_ready) state_d = SLOT_EMPTY;
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         // Payload only moves on a grant, so it holds under stall and
         // keeps its last value after a drain.
         if (grant) begin
            data_q <= alu_result;
            id_q   <= winner;
            err_q  <= alu_err;
         end
      end
   end

   assign bus.rsp_valid = (state_q == SLOT_FULL);
   assign bus.rsp_data  = data_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_err   = err_q;

`ifdef LOGIC_ARB_STATS_EN
   logic [GRANT_CNT_W-1:0] grant_cnt_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else if (grant) begin
         if (grant_cnt_q != '1)           grant_cnt_q <= grant_cnt_q + 1'b1;
         if (alu_err && err_cnt_q != '1)  err_cnt_q   <= err_cnt_q + 1'b1;
      end
   end

   assign grant_cnt = grant_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule
